// File: rtl/spare_logic_checker.sv
// spare_logic_checker: samples the tie-driven spare cell outputs over a
// programmable window and accumulates a sticky per-bit mismatch vector
// plus a saturating count of mismatching samples for firmware readback.
module spare_logic_checker #(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned DIVIDE  = 1,
  parameter int unsigned SAMPLES = 16,
  parameter logic [43:0] EXPECT  = 44'h0FFF8000000,
  parameter logic [43:0] MASK    = 44'h3FFFFFFFFFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [30:0] spare_xz,
  input  logic [3:0]  spare_xi,
  input  logic        spare_xib,
  input  logic [1:0]  spare_xna,
  input  logic [1:0]  spare_xno,
  input  logic [1:0]  spare_xmx,
  input  logic [1:0]  spare_xfq,
  input  logic        start,
  input  logic        clear,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [43:0] err_vec,
  output logic [7:0]  err_count
);

  localparam int unsigned CHK_W = 44;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned ST_W  = $clog2(SETTLE) + 1;
  localparam int unsigned DV_W  = $clog2(DIVIDE) + 1;
  localparam int unsigned SM_W  = $clog2(SAMPLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CHK_W-1:0]   snap_q, snap_d;
  logic [CHK_W-1:0]   err_vec_q, err_vec_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic [ST_W-1:0]    settle_cnt_q, settle_cnt_d;
  logic [DV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [SM_W-1:0]    smp_cnt_q, smp_cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;

  logic [CHK_W-1:0]   chk_c;
  logic [CHK_W-1:0]   miss_c;

  // Pack the spare outputs; bit 0 is spare_xz[0], bit 43 is spare_xfq[1].
  assign chk_c  = {spare_xfq, spare_xmx, spare_xno, spare_xna, spare_xib, spare_xi, spare_xz};
  // Mismatch against the tie-off pattern, using the registered snapshot only.
  assign miss_c = (snap_q ^ EXPECT) & MASK;

  // State register and all result/counter flops.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= S_IDLE;
      snap_q       <= '0;
      err_vec_q    <= '0;
      err_count_q  <= '0;
      settle_cnt_q <= '0;
      div_cnt_q    <= '0;
      smp_cnt_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      err_vec_q    <= err_vec_d;
      err_count_q  <= err_count_d;
      settle_cnt_q <= settle_cnt_d;
      div_cnt_q    <= div_cnt_d;
      smp_cnt_q    <= smp_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  // Next-state, counter and result update; status flops follow next state.
  always_comb begin
    state_d      = state_q;
    snap_d       = chk_c;
    err_vec_d    = err_vec_q;
    err_count_d  = err_count_q;
    settle_cnt_d = settle_cnt_q;
    div_cnt_d    = div_cnt_q;
    smp_cnt_d    = smp_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_SETTLE;
          err_vec_d    = '0;
          err_count_d  = '0;
          settle_cnt_d = ST_W'(SETTLE - 1);
        end else if (clear) begin
          err_vec_d   = '0;
          err_count_d = '0;
        end
      end

      S_SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d   = S_SAMPLE;
          div_cnt_d = '0;
          smp_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q - ST_W'(1);
        end
      end

      S_SAMPLE: begin
        // Finish one edge after the final compare.
        if (smp_cnt_q == SM_W'(SAMPLES)) begin
          state_d = S_DONE;
        end else if (div_cnt_q == '0) begin
          err_vec_d = err_vec_q | miss_c;
          if ((|miss_c) && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + CNT_W'(1);
          end
          smp_cnt_d = smp_cnt_q + SM_W'(1);
          div_cnt_d = DV_W'(DIVIDE - 1);
        end else begin
          div_cnt_d = div_cnt_q - DV_W'(1);
        end
      end

      S_DONE: begin
        if (start) begin
          state_d      = S_SETTLE;
          err_vec_d    = '0;
          err_count_d  = '0;
          settle_cnt_d = ST_W'(SETTLE - 1);
        end else if (clear) begin
          state_d     = S_IDLE;
          err_vec_d   = '0;
          err_count_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_vec_d == '0);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_vec   = err_vec_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_spare_logic_checker.sv
// Directed bench for spare_logic_checker. Four instances share the inputs:
// defaults, unmasked, DIVIDE=4/SAMPLES=8, and SAMPLES=300.
module tb_spare_logic_checker;

  localparam logic [43:0] EXP = 44'h0FFF8000000;
  localparam int D = 0;  // defaults
  localparam int M = 1;  // MASK all ones
  localparam int G = 2;  // DIVIDE=4, SAMPLES=8
  localparam int S = 3;  // SAMPLES=300

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        start;
  logic        clear;
  logic [43:0] chk_drv;

  logic        busy_w      [4];
  logic        done_w      [4];
  logic        pass_w      [4];
  logic [43:0] err_vec_w   [4];
  logic [7:0]  err_count_w [4];

  int n_vec;
  int n_miss;
  int t;

  spare_logic_checker u_dflt (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .spare_xz(chk_drv[30:0]), .spare_xi(chk_drv[34:31]), .spare_xib(chk_drv[35]),
    .spare_xna(chk_drv[37:36]), .spare_xno(chk_drv[39:38]), .spare_xmx(chk_drv[41:40]),
    .spare_xfq(chk_drv[43:42]), .start(start), .clear(clear),
    .busy(busy_w[D]), .done(done_w[D]), .pass(pass_w[D]),
    .err_vec(err_vec_w[D]), .err_count(err_count_w[D])
  );

  spare_logic_checker #(.MASK(44'hFFFFFFFFFFF)) u_mask (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .spare_xz(chk_drv[30:0]), .spare_xi(chk_drv[34:31]), .spare_xib(chk_drv[35]),
    .spare_xna(chk_drv[37:36]), .spare_xno(chk_drv[39:38]), .spare_xmx(chk_drv[41:40]),
    .spare_xfq(chk_drv[43:42]), .start(start), .clear(clear),
    .busy(busy_w[M]), .done(done_w[M]), .pass(pass_w[M]),
    .err_vec(err_vec_w[M]), .err_count(err_count_w[M])
  );

  spare_logic_checker #(.DIVIDE(4), .SAMPLES(8)) u_glitch (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .spare_xz(chk_drv[30:0]), .spare_xi(chk_drv[34:31]), .spare_xib(chk_drv[35]),
    .spare_xna(chk_drv[37:36]), .spare_xno(chk_drv[39:38]), .spare_xmx(chk_drv[41:40]),
    .spare_xfq(chk_drv[43:42]), .start(start), .clear(clear),
    .busy(busy_w[G]), .done(done_w[G]), .pass(pass_w[G]),
    .err_vec(err_vec_w[G]), .err_count(err_count_w[G])
  );

  spare_logic_checker #(.SAMPLES(300)) u_sat (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .spare_xz(chk_drv[30:0]), .spare_xi(chk_drv[34:31]), .spare_xib(chk_drv[35]),
    .spare_xna(chk_drv[37:36]), .spare_xno(chk_drv[39:38]), .spare_xmx(chk_drv[41:40]),
    .spare_xfq(chk_drv[43:42]), .start(start), .clear(clear),
    .busy(busy_w[S]), .done(done_w[S]), .pass(pass_w[S]),
    .err_vec(err_vec_w[S]), .err_count(err_count_w[S])
  );

  // Free-running clock.
  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // Advance n edges; land 1ns after the last one.
  task automatic ticks(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
    t += n;
  endtask

  // Pulse start for one edge; that edge becomes t=0.
  task automatic begin_run();
    start = 1'b1;
    ticks(1);
    start = 1'b0;
    t = 0;
  endtask

  // Let every instance (longest is SAMPLES=300, done at t=305) reach DONE.
  task automatic finish_all();
    if (t < 310) ticks(310 - t);
  endtask

  initial begin
    n_vec    = 0;
    n_miss   = 0;
    t        = 0;
    wb_rst_i = 1'b1;
    start    = 1'b0;
    clear    = 1'b0;
    chk_drv  = EXP;
    ticks(2);

    // Reset state
    check("rst_busy", 64'(busy_w[D]), 64'd0);
    check("rst_done", 64'(done_w[D]), 64'd0);
    check("rst_pass", 64'(pass_w[D]), 64'd0);
    check("rst_vec",  64'(err_vec_w[D]), 64'd0);
    check("rst_cnt",  64'(err_count_w[D]), 64'd0);
    wb_rst_i = 1'b0;
    ticks(1);

    // Nominal run, exact done timing
    begin_run();
    check("nom_busy0", 64'(busy_w[D]), 64'd1);
    ticks(20);
    check("nom_done_t20", 64'(done_w[D]), 64'd0);
    check("nom_busy_t20", 64'(busy_w[D]), 64'd1);
    ticks(1);
    check("nom_done_t21", 64'(done_w[D]), 64'd1);
    check("nom_busy_t21", 64'(busy_w[D]), 64'd0);
    check("nom_pass", 64'(pass_w[D]), 64'd1);
    check("nom_vec",  64'(err_vec_w[D]), 64'd0);
    check("nom_cnt",  64'(err_count_w[D]), 64'd0);
    ticks(13);
    check("nom_g_done_t34", 64'(done_w[G]), 64'd1);
    ticks(270);
    check("nom_s_done_t304", 64'(done_w[S]), 64'd0);
    ticks(1);
    check("nom_s_done_t305", 64'(done_w[S]), 64'd1);
    check("nom_s_pass", 64'(pass_w[S]), 64'd1);
    finish_all();

    // Single stuck bit spare_xz[5]
    chk_drv[5] = 1'b1;
    begin_run();
    ticks(21);
    check("stuck_done", 64'(done_w[D]), 64'd1);
    check("stuck_vec",  64'(err_vec_w[D]), 64'h20);
    check("stuck_cnt",  64'(err_count_w[D]), 64'd16);
    check("stuck_pass", 64'(pass_w[D]), 64'd0);
    finish_all();
    chk_drv = EXP;

    // Flop outputs high: masked by default, caught when unmasked
    chk_drv[43:42] = 2'b11;
    begin_run();
    ticks(21);
    check("mask_dflt_pass", 64'(pass_w[D]), 64'd1);
    check("mask_dflt_vec",  64'(err_vec_w[D]), 64'd0);
    check("mask_all_vec",   64'(err_vec_w[M]), 64'hC0000000000);
    check("mask_all_cnt",   64'(err_count_w[M]), 64'd16);
    check("mask_all_pass",  64'(pass_w[M]), 64'd0);
    finish_all();
    chk_drv = EXP;

    // One-cycle glitch on bit 38 captured into compare 3's snapshot (edge t=16)
    begin_run();
    ticks(15);
    chk_drv[38] = 1'b0;
    ticks(1);
    chk_drv[38] = 1'b1;
    ticks(17);
    check("glitch_done_t33", 64'(done_w[G]), 64'd0);
    ticks(1);
    check("glitch_done_t34", 64'(done_w[G]), 64'd1);
    check("glitch_cnt", 64'(err_count_w[G]), 64'd1);
    check("glitch_vec", 64'(err_vec_w[G]), 64'h04000000000);
    check("glitch_pass", 64'(pass_w[G]), 64'd0);
    finish_all();

    // Same glitch at edge t=18, between compares 3 (t=17) and 4 (t=21)
    begin_run();
    ticks(17);
    chk_drv[38] = 1'b0;
    ticks(1);
    chk_drv[38] = 1'b1;
    ticks(16);
    check("gap_done", 64'(done_w[G]), 64'd1);
    check("gap_pass", 64'(pass_w[G]), 64'd1);
    check("gap_cnt",  64'(err_count_w[G]), 64'd0);
    finish_all();

    // Saturation: inverter outputs low for 300 samples
    chk_drv[34:31] = 4'h0;
    begin_run();
    ticks(304);
    check("sat_done_t304", 64'(done_w[S]), 64'd0);
    ticks(1);
    check("sat_done_t305", 64'(done_w[S]), 64'd1);
    check("sat_cnt", 64'(err_count_w[S]), 64'd255);
    check("sat_vec", 64'(err_vec_w[S]), 64'h00780000000);
    check("sat_dflt_cnt", 64'(err_count_w[D]), 64'd16);
    finish_all();
    chk_drv = EXP;

    // start while busy is ignored
    begin_run();
    ticks(5);
    start = 1'b1;
    ticks(1);
    start = 1'b0;
    ticks(14);
    check("rbusy_done_t20", 64'(done_w[D]), 64'd0);
    ticks(1);
    check("rbusy_done_t21", 64'(done_w[D]), 64'd1);
    finish_all();

    // clear while busy is ignored; clear in DONE zeroes and returns to idle
    chk_drv[5] = 1'b1;
    begin_run();
    ticks(10);
    clear = 1'b1;
    ticks(1);
    clear = 1'b0;
    ticks(10);
    check("cbusy_done", 64'(done_w[D]), 64'd1);
    check("cbusy_cnt",  64'(err_count_w[D]), 64'd16);
    check("cbusy_vec",  64'(err_vec_w[D]), 64'h20);
    finish_all();
    clear = 1'b1;
    ticks(1);
    clear = 1'b0;
    check("cdone_done", 64'(done_w[D]), 64'd0);
    check("cdone_vec",  64'(err_vec_w[D]), 64'd0);
    check("cdone_cnt",  64'(err_count_w[D]), 64'd0);

    // start with clear in DONE: new run with zeroed results
    begin_run();
    finish_all();
    chk_drv = EXP;
    start   = 1'b1;
    clear   = 1'b1;
    ticks(1);
    start   = 1'b0;
    clear   = 1'b0;
    t       = 0;
    check("sc_busy", 64'(busy_w[D]), 64'd1);
    check("sc_done", 64'(done_w[D]), 64'd0);
    check("sc_vec",  64'(err_vec_w[D]), 64'd0);
    check("sc_cnt",  64'(err_count_w[D]), 64'd0);
    ticks(21);
    check("sc_pass", 64'(pass_w[D]), 64'd1);
    finish_all();

    // Reset mid-SAMPLE: compares at t=5..10 have been counted
    chk_drv[5] = 1'b1;
    begin_run();
    ticks(10);
    check("mid_cnt", 64'(err_count_w[D]), 64'd6);
    wb_rst_i = 1'b1;
    ticks(1);
    check("mrst_busy", 64'(busy_w[D]), 64'd0);
    check("mrst_done", 64'(done_w[D]), 64'd0);
    check("mrst_vec",  64'(err_vec_w[D]), 64'd0);
    check("mrst_cnt",  64'(err_count_w[D]), 64'd0);
    wb_rst_i = 1'b0;
    ticks(3);
    check("mrst_stay_idle", 64'(busy_w[D]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
